matmul_mem_arbiter: RTL and testbench

- Arbitrates the single register-file/scratchpad access port between two requesters: the APB slave (host) and the matmul calc engine.
- Uses fixed priority (calc first), a calc lock for multi-beat operand fetch/writeback, and a starvation counter that protects the APB side.
- Tracks ownership of 1-cycle-latency reads so read data returns to the requester that issued the read.
- Sits between apb_slave_module / matmul_calc_module and register_file_module inside the matmul top.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_mem_arbiter_if.sv | 56 +++++
 rtl/matmul_arb_starve_cnt.sv | 27 ++
 rtl/matmul_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_matmul_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types for the matmul memory arbiter: ownership and FSM state enums,
// plus the strobe-width helper used by the interface and the arbiter.
package matmul_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_APB  = 2'd1,
        OWN_CALC = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_APB  = 2'd1,
        ST_OWN_CALC = 2'd2
    } arb_state_e;

    // One strobe bit per element lane on the data bus.
    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

endpackage

// File: rtl/matmul_mem_arbiter_if.sv
// Bus bundle between the two requesters (APB host, calc engine), the arbiter
// and the register file port. The slave modport is the arbiter's view.
interface matmul_mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
);
    import matmul_pkg::*;
    localparam int MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH);

    // Handshake: a requester raises req and holds it (with we/addr/wdata) until it
    // sees gnt; one beat transfers in every cycle where req && gnt. A read beat
    // returns its data one cycle later, qualified by that requester's rvalid.
    logic                  apb_req_i;
    logic                  apb_we_i;
    logic [ADDR_WIDTH-1:0] apb_addr_i;
    logic [BUS_WIDTH-1:0]  apb_wdata_i;
    logic [MAX_DIM-1:0]    apb_strb_i;
    logic                  apb_gnt_o;
    logic                  apb_rvalid_o;
    logic [BUS_WIDTH-1:0]  apb_rdata_o;

    logic                  calc_req_i;
    logic                  calc_we_i;
    logic [ADDR_WIDTH-1:0] calc_addr_i;
    logic [BUS_WIDTH-1:0]  calc_wdata_i;
    logic                  calc_lock_i;
    logic                  calc_gnt_o;
    logic                  calc_rvalid_o;
    logic [BUS_WIDTH-1:0]  calc_rdata_o;

    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BUS_WIDTH-1:0]  mem_wdata_o;
    logic                  mem_we_o;
    logic [MAX_DIM-1:0]    mem_strb_o;
    logic [BUS_WIDTH-1:0]  mem_rdata_i;

    modport slave (
        input  apb_req_i, apb_we_i, apb_addr_i, apb_wdata_i, apb_strb_i,
        output apb_gnt_o, apb_rvalid_o, apb_rdata_o,
        input  calc_req_i, calc_we_i, calc_addr_i, calc_wdata_i, calc_lock_i,
        output calc_gnt_o, calc_rvalid_o, calc_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_we_o, mem_strb_o,
        input  mem_rdata_i
    );

    modport master (
        output apb_req_i, apb_we_i, apb_addr_i, apb_wdata_i, apb_strb_i,
        input  apb_gnt_o, apb_rvalid_o, apb_rdata_o,
        output calc_req_i, calc_we_i, calc_addr_i, calc_wdata_i, calc_lock_i,
        input  calc_gnt_o, calc_rvalid_o, calc_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o, mem_strb_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/matmul_arb_starve_cnt.sv
// Saturating wait counter for the APB side of the arbiter; clear wins over
// increment, and at_limit_o flags that the APB side has waited long enough.
module matmul_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/matmul_mem_arbiter.sv
// Arbiter for the single register-file port shared by the APB host and the calc
// engine. Define MATMUL_ARB_RR_EN for round-robin on simultaneous requests.
module matmul_mem_arbiter
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    matmul_mem_arbiter_if.slave  bus,
    output logic                 busy_o,
    output arb_state_e           state_o
);
    localparam int MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH);

    arb_state_e state_q, state_d;
    owner_e     rd_owner_q;
    logic       busy_q;
    logic       apb_gnt, calc_gnt;
    logic       at_limit, starve_clr, starve_inc;

    logic [ADDR_WIDTH-1:0] mux_addr;
    logic [BUS_WIDTH-1:0]  mux_wdata;
    logic [MAX_DIM-1:0]    mux_strb;
    logic                  mux_we;

`ifdef MATMUL_ARB_RR_EN
    owner_e last_owner_q;
`endif

    assign apb_gnt  = (state_q == ST_OWN_APB)  && bus.apb_req_i;
    assign calc_gnt = (state_q == ST_OWN_CALC) && bus.calc_req_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef MATMUL_ARB_RR_EN
                if (bus.calc_req_i && bus.apb_req_i) begin
                    state_d = (last_owner_q == OWN_CALC) ? ST_OWN_APB : ST_OWN_CALC;
                end else if (bus.calc_req_i) begin
                    state_d = ST_OWN_CALC;
                end else if (bus.apb_req_i) begin
                    state_d = ST_OWN_APB;
                end
`else
                if (bus.calc_req_i) begin
                    state_d = ST_OWN_CALC;
                end else if (bus.apb_req_i) begin
                    state_d = ST_OWN_APB;
                end
`endif
            end
            ST_OWN_CALC: begin
                // A held lock defers both the voluntary release and the forced handover.
                if (!bus.calc_lock_i && ((!bus.calc_req_i && bus.apb_req_i) || at_limit)) begin
                    state_d = ST_OWN_APB;
                end else if (!bus.calc_lock_i && !bus.calc_req_i && !bus.apb_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_APB: begin
                if (!bus.apb_req_i) begin
                    state_d = bus.calc_req_i ? ST_OWN_CALC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign starve_inc = (state_q == ST_OWN_CALC) && bus.apb_req_i;
    assign starve_clr = !bus.apb_req_i ||
                        ((state_d == ST_OWN_APB) && (state_q != ST_OWN_APB));

    matmul_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (starve_clr),
        .inc_i      (starve_inc),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            if (apb_gnt && !bus.apb_we_i) begin
                rd_owner_q <= OWN_APB;
            end else if (calc_gnt && !bus.calc_we_i) begin
                rd_owner_q <= OWN_CALC;
            end else begin
                rd_owner_q <= OWN_NONE;
            end
        end
    end

`ifdef MATMUL_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_q <= OWN_CALC;
        end else if (state_q == ST_OWN_APB) begin
            last_owner_q <= OWN_APB;
        end else if (state_q == ST_OWN_CALC) begin
            last_owner_q <= OWN_CALC;
        end
    end
`endif

    always_comb begin
        mux_addr  = '0;
        mux_wdata = '0;
        mux_strb  = '0;
        mux_we    = 1'b0;
        if (calc_gnt) begin
            mux_addr  = bus.calc_addr_i;
            mux_wdata = bus.calc_wdata_i;
            mux_strb  = '1;
            mux_we    = bus.calc_we_i;
        end else if (apb_gnt) begin
            mux_addr  = bus.apb_addr_i;
            mux_wdata = bus.apb_wdata_i;
            mux_strb  = bus.apb_strb_i;
            mux_we    = bus.apb_we_i;
        end
    end

    assign bus.apb_gnt_o   = apb_gnt;
    assign bus.calc_gnt_o  = calc_gnt;
    assign bus.mem_addr_o  = mux_addr;
    assign bus.mem_wdata_o = mux_wdata;
    assign bus.mem_strb_o  = mux_strb;
    assign bus.mem_we_o    = mux_we;

    // Read return is masked while reset is asserted so a read in flight is dropped.
    assign bus.apb_rvalid_o  = (rd_owner_q == OWN_APB)  && !rst_i;
    assign bus.calc_rvalid_o = (rd_owner_q == OWN_CALC) && !rst_i;
    assign bus.apb_rdata_o   = bus.apb_rvalid_o  ? bus.mem_rdata_i : '0;
    assign bus.calc_rdata_o  = bus.calc_rvalid_o ? bus.mem_rdata_i : '0;

    assign busy_o  = busy_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_matmul_mem_arbiter.sv
// Self-checking bench for matmul_mem_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against an ownership-level model.
module tb_matmul_mem_arbiter;
    import matmul_pkg::*;

    localparam int DW = 8;
    localparam int BW = 16;
    localparam int AW = 32;
    localparam int SL = 4;
    localparam int MD = BW / DW;
    localparam logic [1:0] N_NONE = 2'd0;
    localparam logic [1:0] N_APB  = 2'd1;
    localparam logic [1:0] N_CALC = 2'd2;
`ifdef MATMUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    arb_state_e state;

    matmul_mem_arbiter_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    matmul_mem_arbiter #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .busy_o  (busy),
        .state_o (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0] m_owner;   // who holds the port
    int         m_wait;    // cycles APB has waited under calc ownership
    logic [1:0] m_last;    // most recent owner, for round-robin
    logic       m_ag, m_cg;
    logic [1:0] exp_q[$];  // read-return owner expected in each upcoming cycle

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = N_NONE;
        m_wait  = 0;
        m_last  = N_CALC;
        m_ag    = 1'b0;
        m_cg    = 1'b0;
        exp_q.delete();
        exp_q.push_back(N_NONE);
    endtask

    task automatic compare_all();
        logic [1:0]    rd;
        logic [AW-1:0] ea;
        logic [BW-1:0] ew;
        logic [MD-1:0] es;
        logic          ewe;
        arb_state_e    est;
        rd = N_NONE;
        if (exp_q.size() > 0) rd = exp_q.pop_front();
        if (rst) rd = N_NONE;
        m_ag = (m_owner == N_APB)  && bus.apb_req_i;
        m_cg = (m_owner == N_CALC) && bus.calc_req_i;
        ea = '0; ew = '0; es = '0; ewe = 1'b0;
        if (m_cg) begin
            ea = bus.calc_addr_i; ew = bus.calc_wdata_i; es = '1; ewe = bus.calc_we_i;
        end else if (m_ag) begin
            ea = bus.apb_addr_i; ew = bus.apb_wdata_i; es = bus.apb_strb_i; ewe = bus.apb_we_i;
        end
        est = (m_owner == N_APB) ? ST_OWN_APB : (m_owner == N_CALC) ? ST_OWN_CALC : ST_IDLE;
        check("apb_gnt",     bus.apb_gnt_o,     m_ag);
        check("calc_gnt",    bus.calc_gnt_o,    m_cg);
        check("mem_addr",    bus.mem_addr_o,    ea);
        check("mem_wdata",   bus.mem_wdata_o,   ew);
        check("mem_strb",    bus.mem_strb_o,    es);
        check("mem_we",      bus.mem_we_o,      ewe);
        check("busy",        busy,              m_owner != N_NONE);
        check("state",       state,             est);
        check("apb_rvalid",  bus.apb_rvalid_o,  rd == N_APB);
        check("apb_rdata",   bus.apb_rdata_o,   (rd == N_APB)  ? bus.mem_rdata_i : '0);
        check("calc_rvalid", bus.calc_rvalid_o, rd == N_CALC);
        check("calc_rdata",  bus.calc_rdata_o,  (rd == N_CALC) ? bus.mem_rdata_i : '0);
    endtask

    task automatic model_update();
        logic [1:0] nxt;
        logic ar, cr, lk;
        if (rst) begin
            model_reset();
            return;
        end
        ar = bus.apb_req_i; cr = bus.calc_req_i; lk = bus.calc_lock_i;
        if (m_ag && !bus.apb_we_i)       exp_q.push_back(N_APB);
        else if (m_cg && !bus.calc_we_i) exp_q.push_back(N_CALC);
        else                             exp_q.push_back(N_NONE);
        nxt = m_owner;
        case (m_owner)
            N_NONE: begin
                if (cr && ar) nxt = (RR && m_last == N_CALC) ? N_APB : N_CALC;
                else if (cr)  nxt = N_CALC;
                else if (ar)  nxt = N_APB;
            end
            N_CALC: begin
                if (!lk && ((!cr && ar) || m_wait == SL)) nxt = N_APB;
                else if (!lk && !cr && !ar)              nxt = N_NONE;
            end
            default: begin
                if (!ar) nxt = cr ? N_CALC : N_NONE;
            end
        endcase
        if (!ar || (nxt == N_APB && m_owner != N_APB)) m_wait = 0;
        else if (m_owner == N_CALC && m_wait < SL)     m_wait = m_wait + 1;
        if (m_owner != N_NONE) m_last = m_owner;
        m_owner = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.apb_req_i = 1'b0; bus.apb_we_i = 1'b0; bus.apb_addr_i = '0;
        bus.apb_wdata_i = '0; bus.apb_strb_i = '0;
        bus.calc_req_i = 1'b0; bus.calc_we_i = 1'b0; bus.calc_addr_i = '0;
        bus.calc_wdata_i = '0; bus.calc_lock_i = 1'b0;
    endtask

    task automatic drive_apb(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd);
        bus.apb_req_i = 1'b1; bus.apb_we_i = we; bus.apb_addr_i = addr;
        bus.apb_wdata_i = wd; bus.apb_strb_i = '1;
    endtask

    task automatic drive_calc(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                              input logic lock);
        bus.calc_req_i = 1'b1; bus.calc_we_i = we; bus.calc_addr_i = addr;
        bus.calc_wdata_i = wd; bus.calc_lock_i = lock;
    endtask

    task automatic randomize_inputs();
        if (!(bus.apb_req_i && !m_ag)) begin
            bus.apb_req_i   = ($urandom_range(0, 2) != 0);
            bus.apb_we_i    = $urandom_range(0, 1);
            bus.apb_addr_i  = AW'($urandom_range(0, 255));
            bus.apb_wdata_i = BW'($urandom);
            bus.apb_strb_i  = MD'($urandom);
        end
        bus.calc_req_i   = ($urandom_range(0, 3) != 0);
        bus.calc_we_i    = $urandom_range(0, 1);
        bus.calc_addr_i  = AW'($urandom_range(0, 255));
        bus.calc_wdata_i = BW'($urandom);
        bus.calc_lock_i  = ($urandom_range(0, 4) == 0);
        bus.mem_rdata_i  = BW'($urandom);
        rst              = ($urandom_range(0, 63) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        bus.mem_rdata_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // reset state
        #1;
        check("rst_state", state, ST_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_addr", bus.mem_addr_o, '0);
        step();

        // simultaneous requests from IDLE
        drive_calc(1'b1, 32'h40, 16'hBEEF, 1'b0);
        drive_apb(1'b0, 32'h44, 16'h0);
        step();
        #1;
        check("simul_calc_gnt", bus.calc_gnt_o, RR ? 1'b0 : 1'b1);
        check("simul_apb_gnt",  bus.apb_gnt_o,  RR ? 1'b1 : 1'b0);
        step();
        bus.calc_req_i = 1'b0;
        step();
        step();
        drive_idle();
        repeat (3) step();

        // single APB read
        bus.mem_rdata_i = 16'h1234;
        drive_apb(1'b0, 32'h10, 16'h0);
        #1; check("apb_rd_gnt_c0", bus.apb_gnt_o, 1'b0);
        step();
        #1;
        check("apb_rd_gnt_c1", bus.apb_gnt_o, 1'b1);
        check("apb_rd_busy_c1", busy, 1'b1);
        check("apb_rd_addr_c1", bus.mem_addr_o, 32'h10);
        step();
        bus.apb_req_i = 1'b0;
        #1;
        check("apb_rd_rvalid_c2", bus.apb_rvalid_o, 1'b1);
        check("apb_rd_rdata_c2", bus.apb_rdata_o, 16'h1234);
        step();
        repeat (2) step();

        // starvation handover, unlocked calc stream
        drive_calc(1'b1, 32'h80, 16'h1111, 1'b0);
        drive_apb(1'b0, 32'h90, 16'h0);
        step();
        for (int i = 0; i <= SL; i++) begin
            #1; check("starve_calc_hold", bus.calc_gnt_o, 1'b1);
            step();
        end
        #1;
        check("starve_apb_gnt", bus.apb_gnt_o, 1'b1);
        check("starve_calc_gnt", bus.calc_gnt_o, 1'b0);
        step();
        bus.apb_req_i = 1'b0;
        step();
        drive_idle();
        repeat (3) step();

        // starvation deferred by lock
        drive_calc(1'b1, 32'h84, 16'h2222, 1'b1);
        drive_apb(1'b1, 32'h94, 16'h3333);
        step();
        for (int i = 0; i < 10; i++) begin
            #1; check("lock_apb_blocked", bus.apb_gnt_o, 1'b0);
            step();
        end
        bus.calc_lock_i = 1'b0;
        #1; check("lock_release_calc", bus.calc_gnt_o, 1'b1);
        step();
        #1;
        check("lock_apb_gnt", bus.apb_gnt_o, 1'b1);
        check("lock_calc_gnt", bus.calc_gnt_o, 1'b0);
        step();
        drive_idle();
        repeat (3) step();

        // calc reads returning across a forced handover
        bus.mem_rdata_i = 16'h5A5A;
        drive_calc(1'b0, 32'h20, 16'h0, 1'b0);
        drive_apb(1'b1, 32'h30, 16'h7777);
        step();
        for (int i = 0; i <= SL; i++) step();
        #1;
        check("xfer_apb_gnt", bus.apb_gnt_o, 1'b1);
        check("xfer_calc_rvalid", bus.calc_rvalid_o, 1'b1);
        check("xfer_calc_rdata", bus.calc_rdata_o, 16'h5A5A);
        check("xfer_apb_rvalid", bus.apb_rvalid_o, 1'b0);
        check("xfer_apb_rdata", bus.apb_rdata_o, 16'h0);
        step();
        drive_idle();
        repeat (3) step();

        // reset the cycle after a granted read
        drive_apb(1'b0, 32'h18, 16'h0);
        step();
        step();
        bus.apb_req_i = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", bus.apb_rvalid_o, 1'b0);
        check("mid_rst_rdata", bus.apb_rdata_o, 16'h0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_state", state, ST_IDLE);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_rvalid", bus.apb_rvalid_o, 1'b0);
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            step();
        end
        rst = 1'b0;
        drive_idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
